// File: rtl/lut_table_mc_csr_pkg.sv
// lut_table_mc_csr_pkg: register map, field positions and AXI responses for lut_table_csr_mc.
package lut_table_mc_csr_pkg;
    localparam int LUT_CTRL_CR   = 0;
    localparam int LUT_ADDR_CR   = 1;
    localparam int LUT_DATA_CR   = 2;
    localparam int LUT_STATUS_SR = 3;
    localparam int TOTAL_CSR_CNT = 4;
    localparam int AUTO_INC_BIT  = 0;
    localparam int CH_MASK_LSB   = 8;
    localparam int RD_BUSY_BIT   = 0;
    localparam int WRAP_BIT      = 1;
    localparam int WR_CNT_LSB    = 16;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_merge(logic [31:0] cur, logic [31:0] wdata, logic [3:0] strb);
        for (int i = 0; i < 4; i++)
            cur[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
        return cur;
    endfunction
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: 32-bit AXI4-Lite bundle with master/slave views.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    modport slave (input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                   output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
    modport master (output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/lut_rd_latency_pipe.sv
// lut_rd_latency_pipe: DEPTH-deep valid shift register timing LUT readback capture.
module lut_rd_latency_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    output logic done
);
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sr <= '0;
        else       sr <= (sr << 1) | DEPTH'(start);
    end

    assign done = sr[DEPTH-1];
endmodule

// File: rtl/lut_table_csr_mc.sv
// lut_table_csr_mc: AXI4-Lite CSR slave programming per-channel pixel LUTs.
// Define LUT_CSR_READBACK_EN to read LUT contents back through LUT_DATA.
module lut_table_csr_mc
    import lut_table_mc_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          PX_WIDTH   = 10,
    parameter int          CHANNELS   = 3,
    parameter int          RD_LATENCY = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    axi4_lite_if.slave                   csr_i,
    output logic [CHANNELS-1:0]          lut_ch_o,
    output logic [PX_WIDTH-1:0]          lut_orig_px_o,
    output logic [PX_WIDTH-1:0]          lut_mod_px_o,
    output logic                         lut_wr_stb_o,
    output logic                         lut_rd_stb_o,
    input  logic [CHANNELS*PX_WIDTH-1:0] lut_rd_data_i
);
    logic                aw_held, w_held, bvalid, rvalid, rd_busy, auto_inc, wrap;
    logic [31:0]         aw_addr_q, wdata_q, rdata;
    logic [3:0]          wstrb_q, ws;
    logic [1:0]          bresp, rresp, w_idx, r_idx;
    logic [CHANNELS-1:0] ch_mask;
    logic [PX_WIDTH-1:0] lut_addr, lut_data, rb_data, addr_inc;
    logic [15:0]         wr_cnt;
    logic [31:0]         regs [TOTAL_CSR_CNT];
    logic [31:0]         wa, wd, w_off, r_off, merged;
    logic                aw_hs, w_hs, ar_hs, do_commit, w_map, r_map, rb_start, rb_done, unused_bits;

    assign csr_i.awready = !aw_held && !bvalid;
    assign csr_i.wready  = !w_held && !bvalid;
    assign csr_i.arready = !rvalid && !rd_busy;
    assign csr_i.bvalid  = bvalid;
    assign csr_i.bresp   = bresp;
    assign csr_i.rvalid  = rvalid;
    assign csr_i.rresp   = rresp;
    assign csr_i.rdata   = rdata;

    assign aw_hs = csr_i.awvalid && csr_i.awready;
    assign w_hs  = csr_i.wvalid && csr_i.wready;
    assign ar_hs = csr_i.arvalid && csr_i.arready;
    assign wa    = aw_held ? aw_addr_q : csr_i.awaddr;
    assign wd    = w_held ? wdata_q : csr_i.wdata;
    assign ws    = w_held ? wstrb_q : csr_i.wstrb;
    assign w_off = wa - BASE_ADDR;
    assign r_off = csr_i.araddr - BASE_ADDR;
    assign w_map = w_off < 32'(4 * TOTAL_CSR_CNT);
    assign r_map = r_off < 32'(4 * TOTAL_CSR_CNT);
    assign w_idx = w_off[3:2];
    assign r_idx = r_off[3:2];
    assign addr_inc = lut_addr + PX_WIDTH'(1);

    assign regs[LUT_CTRL_CR]   = (32'(ch_mask) << CH_MASK_LSB) | (32'(auto_inc) << AUTO_INC_BIT);
    assign regs[LUT_ADDR_CR]   = 32'(lut_addr);
    assign regs[LUT_STATUS_SR] = (32'(wr_cnt) << WR_CNT_LSB) | (32'(wrap) << WRAP_BIT) | (32'(rd_busy) << RD_BUSY_BIT);
    assign merged = strb_merge(regs[w_idx], wd, ws);
    assign unused_bits = ^{merged, w_off, r_off, lut_rd_data_i, lut_data};

`ifdef LUT_CSR_READBACK_EN
    assign regs[LUT_DATA_CR] = '0;
    assign rb_start = ar_hs && r_map && r_idx == 2'(LUT_DATA_CR) && |ch_mask;

    lut_rd_latency_pipe #(.DEPTH(RD_LATENCY)) u_rd_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (lut_rd_stb_o),
        .done  (rb_done)
    );

    // descending scan so the lowest enabled channel wins
    always_comb begin
        rb_data = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            rb_data = ch_mask[k] ? lut_rd_data_i[k*PX_WIDTH +: PX_WIDTH] : rb_data;
    end
`else
    assign regs[LUT_DATA_CR] = 32'(lut_data);
    assign rb_start = 1'b0;
    assign rb_done  = 1'b0;
    assign rb_data  = '0;
`endif

    // a readback in flight (or starting now) owns the LUT port, so commits wait
    assign do_commit = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid && !rd_busy && !rb_start;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid        <= 1'b0;
            bresp         <= RESP_OKAY;
            rvalid        <= 1'b0;
            rresp         <= RESP_OKAY;
            rdata         <= '0;
            rd_busy       <= 1'b0;
            auto_inc      <= 1'b0;
            ch_mask       <= '0;
            lut_addr      <= '0;
            lut_data      <= '0;
            wrap          <= 1'b0;
            wr_cnt        <= '0;
            lut_wr_stb_o  <= 1'b0;
            lut_rd_stb_o  <= 1'b0;
            lut_ch_o      <= '0;
            lut_orig_px_o <= '0;
            lut_mod_px_o  <= '0;
        end else begin
            lut_wr_stb_o <= 1'b0;
            lut_rd_stb_o <= 1'b0;
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= csr_i.awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= csr_i.wdata;
                wstrb_q <= csr_i.wstrb;
            end
            if (bvalid && csr_i.bready) bvalid <= 1'b0;
            if (rvalid && csr_i.rready) rvalid <= 1'b0;
            if (do_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_map ? RESP_OKAY : RESP_SLVERR;
                if (w_map && w_idx == 2'(LUT_CTRL_CR)) begin
                    auto_inc <= merged[AUTO_INC_BIT];
                    ch_mask  <= merged[CH_MASK_LSB +: CHANNELS];
                end
                if (w_map && w_idx == 2'(LUT_ADDR_CR)) begin
                    lut_addr <= merged[PX_WIDTH-1:0];
                    wrap     <= 1'b0;
                    wr_cnt   <= '0;
                end
                if (w_map && w_idx == 2'(LUT_DATA_CR)) begin
                    lut_data      <= merged[PX_WIDTH-1:0];
                    lut_wr_stb_o  <= 1'b1;
                    lut_orig_px_o <= lut_addr;
                    lut_mod_px_o  <= wd[PX_WIDTH-1:0];
                    lut_ch_o      <= ch_mask;
                    wr_cnt        <= wr_cnt + 16'(~&wr_cnt);
                    if (auto_inc) begin
                        lut_addr <= addr_inc;
                        wrap     <= wrap | &lut_addr;
                    end
                end
            end
            if (ar_hs) begin
                rresp        <= r_map ? RESP_OKAY : RESP_SLVERR;
                rdata        <= (r_map && !rb_start) ? regs[r_idx] : '0;
                rvalid       <= !rb_start;
                rd_busy      <= rb_start;
                lut_rd_stb_o <= rb_start;
                if (rb_start) begin
                    lut_orig_px_o <= lut_addr;
                    lut_ch_o      <= ch_mask;
                end
            end
            if (rb_done) begin
                rdata   <= 32'(rb_data);
                rvalid  <= 1'b1;
                rd_busy <= 1'b0;
                if (auto_inc) begin
                    lut_addr <= addr_inc;
                    wrap     <= wrap | &lut_addr;
                end
            end
        end
    end
endmodule
